// File: rtl/ecc_err_logger.sv
`default_nettype none
// ============================================================================
// Module   : ecc_err_logger
// Brief    : ECC read-path error logger. Captures SEC/DED/parity-only error
//            events (type + word address) into a small event FIFO, keeps
//            saturating SEC/DED counters, sticky W1C status and a masked,
//            registered level interrupt. Zero-wait APB3 slave for firmware.
// Options  : define ECC_ERR_LOG_TIMESTAMP_EN to store a 16-bit free-running
//            cycle stamp per entry, readable at 0x014 (LOG_TS).
// Revision : 1.0 - initial release
// ============================================================================
module ecc_err_logger #(
   parameter int ADDR_WIDTH     = 5,
   parameter int REG_ADDR_WIDTH = 10,
   parameter int LOG_DEPTH      = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      ECC_err_log_clk,
   input  logic                      ECC_err_log_rstn,
   input  logic                      ECC_err_log_sw_rst,
   input  logic                      err_valid_i,
   input  logic [31:0]               error_type_i,
   input  logic [ADDR_WIDTH-1:0]     err_addr_i,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [REG_ADDR_WIDTH-1:0] paddr,
   input  logic [31:0]               pwdata,
   output logic [31:0]               prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic                      ecc_irq_o
);

   localparam int PTR_W = $clog2(LOG_DEPTH);
   localparam int ENT_W = ADDR_WIDTH + 2;

   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_status  = REG_ADDR_WIDTH'(12'h000);
   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_sec_cnt = REG_ADDR_WIDTH'(12'h004);
   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_ded_cnt = REG_ADDR_WIDTH'(12'h008);
   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_log_pop = REG_ADDR_WIDTH'(12'h00C);
   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_irq_msk = REG_ADDR_WIDTH'(12'h010);
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
   localparam logic [REG_ADDR_WIDTH-1:0] c_addr_log_ts  = REG_ADDR_WIDTH'(12'h014);
`endif

   // State: FIFO storage/pointers, counters, sticky {OVF,DED,SEC}, mask, irq
   logic [ENT_W-1:0]     mem_q [LOG_DEPTH];
   logic [ENT_W-1:0]     mem_d [LOG_DEPTH];
   logic [PTR_W:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
   logic [2:0]           status_q, status_d;
   logic [2:0]           irq_mask_q, irq_mask_d;
   logic                 irq_q, irq_d;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
   logic [15:0]          ts_mem_q [LOG_DEPTH];
   logic [15:0]          ts_mem_d [LOG_DEPTH];
   logic [15:0]          ts_q, ts_d;
`endif

   logic                 acc, wr_acc, rd_acc;
   logic                 fifo_empty, fifo_full;
   logic                 ev, ev_sec, ev_ded, push, pop;
   logic [ENT_W-1:0]     head;
   logic [2:0]           w1c;
   logic                 unused_bits;

   assign pready      = 1'b1;
   assign ecc_irq_o   = irq_q;
   // Upper type bits and most write-data bits carry no meaning here.
   assign unused_bits = ^{error_type_i[31:2], pwdata[31:5], pwdata[3]};

   // Event classification, FIFO flags and APB access qualification
   always_comb begin
      acc        = psel & penable;
      wr_acc     = acc & pwrite;
      rd_acc     = acc & ~pwrite;
      fifo_empty = (wptr_q == rptr_q);
      fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
      head       = mem_q[rptr_q[PTR_W-1:0]];
      ev         = err_valid_i & (error_type_i[1:0] != 2'b00);
      ev_sec     = ev & error_type_i[0];
      ev_ded     = ev & (error_type_i[1:0] == 2'b10);
      pop        = rd_acc & (paddr == c_addr_log_pop) & ~fifo_empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push       = ev & (~fifo_full | pop);
      w1c        = (wr_acc && paddr == c_addr_status) ?
                   {pwdata[4], pwdata[1:0]} : 3'b000;
   end

   // Next-state for all registers; soft reset mirrors the async reset
   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      sec_cnt_d  = sec_cnt_q;
      ded_cnt_d  = ded_cnt_q;
      status_d   = status_q;
      irq_mask_d = irq_mask_q;
      irq_d      = irq_q;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
      ts_mem_d   = ts_mem_q;
      ts_d       = ts_q + 16'd1;
`endif
      if (ECC_err_log_sw_rst) begin
         mem_d      = '{default: '0};
         wptr_d     = '0;
         rptr_d     = '0;
         sec_cnt_d  = '0;
         ded_cnt_d  = '0;
         status_d   = '0;
         irq_mask_d = '0;
         irq_d      = 1'b0;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
         ts_mem_d   = '{default: '0};
         ts_d       = '0;
`endif
      end else begin
         if (push) begin
            mem_d[wptr_q[PTR_W-1:0]] = {error_type_i[1:0], err_addr_i};
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
            ts_mem_d[wptr_q[PTR_W-1:0]] = ts_q;
`endif
            wptr_d = wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_d = rptr_q + 1'b1;
         end
         // Firmware clear wins over a coincident increment.
         if (wr_acc && paddr == c_addr_sec_cnt) begin
            sec_cnt_d = '0;
         end else if (ev_sec && sec_cnt_q != '1) begin
            sec_cnt_d = sec_cnt_q + 1'b1;
         end
         if (wr_acc && paddr == c_addr_ded_cnt) begin
            ded_cnt_d = '0;
         end else if (ev_ded && ded_cnt_q != '1) begin
            ded_cnt_d = ded_cnt_q + 1'b1;
         end
         // Event set beats W1C in the same cycle.
         status_d = (status_q & ~w1c) | {ev & ~push, ev_ded, ev_sec};
         if (wr_acc && paddr == c_addr_irq_msk) begin
            irq_mask_d = pwdata[2:0];
         end
         irq_d = |(status_q & irq_mask_q);
      end
   end

   // Register bank with asynchronous active-low reset
   always_ff @(posedge ECC_err_log_clk or negedge ECC_err_log_rstn) begin
      if (!ECC_err_log_rstn) begin
         mem_q      <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
         status_q   <= '0;
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
         ts_mem_q   <= '{default: '0};
         ts_q       <= '0;
`endif
      end else begin
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sec_cnt_q  <= sec_cnt_d;
         ded_cnt_q  <= ded_cnt_d;
         status_q   <= status_d;
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
         ts_mem_q   <= ts_mem_d;
         ts_q       <= ts_d;
`endif
      end
   end

   // APB read mux and slave-error decode, only live during the access phase
   always_comb begin
      prdata  = '0;
      pslverr = 1'b0;
      if (acc && !ECC_err_log_sw_rst) begin
         case (paddr)
            c_addr_status:  if (rd_acc) prdata = 32'({status_q[2], fifo_full, fifo_empty, status_q[1:0]});
            c_addr_sec_cnt: if (rd_acc) prdata = 32'(sec_cnt_q);
            c_addr_ded_cnt: if (rd_acc) prdata = 32'(ded_cnt_q);
            c_addr_log_pop: if (rd_acc && !fifo_empty) prdata = 32'h8000_0000 | 32'(head);
            c_addr_irq_msk: if (rd_acc) prdata = 32'(irq_mask_q);
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
            c_addr_log_ts:  if (rd_acc && !fifo_empty) prdata = 32'(ts_mem_q[rptr_q[PTR_W-1:0]]);
`endif
            default:        pslverr = 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ecc_err_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_err_logger
// Brief    : Directed self-checking bench for ecc_err_logger (CNT_WIDTH=4 so
//            counter saturation is reachable in a short run).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_err_logger;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sw_rst = 1'b0;
   logic        err_valid = 1'b0;
   logic [31:0] err_type = '0;
   logic [4:0]  err_addr = '0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [9:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr, irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd_data;
   logic        rd_err;

   ecc_err_logger #(
      .ADDR_WIDTH(5), .REG_ADDR_WIDTH(10), .LOG_DEPTH(4), .CNT_WIDTH(4)
   ) dut (
      .ECC_err_log_clk(clk), .ECC_err_log_rstn(rst_n), .ECC_err_log_sw_rst(sw_rst),
      .err_valid_i(err_valid), .error_type_i(err_type), .err_addr_i(err_addr),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .ecc_irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Each bus task starts and ends just after a falling edge.
   task automatic apb_rd(input logic [9:0] a, output logic [31:0] d, output logic e);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk); penable = 1'b1; #1;
      d = prdata; e = pslverr;
      @(negedge clk); psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_wr(input logic [9:0] a, input logic [31:0] v);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_rd(a, d, e);
      chk(tag, d, exp);
      chk({tag, "_slverr"}, {31'b0, e}, 32'd0);
   endtask

   task automatic event_in(input logic [31:0] t, input logic [4:0] a);
      err_valid = 1'b1; err_type = t; err_addr = a;
      @(negedge clk);
      err_valid = 1'b0; err_type = '0; err_addr = '0;
   endtask

   initial begin
      // Reset and idle outputs
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("pready", {31'b0, pready}, 32'd1);
      chk("irq_reset", {31'b0, irq}, 32'd0);
      chk("prdata_idle", prdata, 32'd0);
      chk("slverr_idle", {31'b0, pslverr}, 32'd0);
      rd_chk("status_reset", 10'h000, 32'h4);
      rd_chk("sec_reset", 10'h004, 32'h0);
      rd_chk("ded_reset", 10'h008, 32'h0);
      rd_chk("pop_reset", 10'h00C, 32'h0);
      rd_chk("mask_reset", 10'h010, 32'h0);

      // SEC @5, DED @9, pop both in order
      event_in(32'h1, 5'd5);
      event_in(32'h2, 5'd9);
      rd_chk("pop_sec", 10'h00C, 32'h8000_0025);
      rd_chk("pop_ded", 10'h00C, 32'h8000_0049);
      rd_chk("sec_cnt_1", 10'h004, 32'h1);
      rd_chk("ded_cnt_1", 10'h008, 32'h1);
      rd_chk("status_07", 10'h000, 32'h7);
      rd_chk("pop_empty", 10'h00C, 32'h0);

      // W1C and counter clears; type 00 with valid is not an event
      apb_wr(10'h000, 32'h13);
      apb_wr(10'h004, 32'h0);
      apb_wr(10'h008, 32'hFFFF_FFFF);
      event_in(32'hFFFF_FFFC, 5'd3);
      rd_chk("status_cleared", 10'h000, 32'h4);
      rd_chk("sec_none", 10'h004, 32'h0);
      rd_chk("ded_none", 10'h008, 32'h0);
      rd_chk("pop_none", 10'h00C, 32'h0);

      // Parity-only (type 11) counts as SEC; upper type bits ignored
      event_in(32'hFFFF_FFFF, 5'h1F);
      rd_chk("pop_parity", 10'h00C, 32'h8000_007F);
      rd_chk("sec_parity", 10'h004, 32'h1);
      rd_chk("status_parity", 10'h000, 32'h5);
      apb_wr(10'h000, 32'h13);
      apb_wr(10'h004, 32'h0);

      // Overflow with OVF interrupt enabled
      apb_wr(10'h010, 32'h4);
      rd_chk("mask_rb", 10'h010, 32'h4);
      for (int i = 0; i < 5; i++) event_in(32'h1, 5'(i));
      chk("irq_not_yet", {31'b0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_rise", {31'b0, irq}, 32'd1);
      rd_chk("status_ovf", 10'h000, 32'h19);
      rd_chk("sec_cnt_5", 10'h004, 32'h5);
      apb_wr(10'h000, 32'h10);
      chk("irq_hold", {31'b0, irq}, 32'd1);
      @(negedge clk);
      chk("irq_drop", {31'b0, irq}, 32'd0);
      rd_chk("status_ovf_clr", 10'h000, 32'h9);

      // Full FIFO: event and pop in the same cycle
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h00C;
      @(negedge clk);
      penable = 1'b1;
      err_valid = 1'b1; err_type = 32'h1; err_addr = 5'h15;
      #1;
      chk("pop_simul", prdata, 32'h8000_0020);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      err_valid = 1'b0; err_type = '0; err_addr = '0;
      rd_chk("status_simul", 10'h000, 32'h9);
      rd_chk("pop_a1", 10'h00C, 32'h8000_0021);
      rd_chk("pop_a2", 10'h00C, 32'h8000_0022);
      rd_chk("pop_a3", 10'h00C, 32'h8000_0023);
      rd_chk("pop_new", 10'h00C, 32'h8000_0035);
      rd_chk("pop_drained", 10'h00C, 32'h0);
      rd_chk("status_drained", 10'h000, 32'h5);
      rd_chk("sec_cnt_6", 10'h004, 32'h6);

      // DED counter saturation at 4 bits, then clear
      for (int i = 0; i < 20; i++) event_in(32'h2, 5'(i));
      rd_chk("ded_sat", 10'h008, 32'hF);
      apb_wr(10'h008, 32'h1);
      rd_chk("ded_clr", 10'h008, 32'h0);

      // Unmapped offset
      apb_rd(10'h03C, rd_data, rd_err);
      chk("unmapped_data", rd_data, 32'h0);
      chk("unmapped_err", {31'b0, rd_err}, 32'd1);

      // Soft reset clears everything, including a pending interrupt
      @(negedge clk);
      chk("irq_pre_swrst", {31'b0, irq}, 32'd1);
      sw_rst = 1'b1;
      @(negedge clk);
      sw_rst = 1'b0;
      chk("irq_swrst", {31'b0, irq}, 32'd0);
      rd_chk("status_swrst", 10'h000, 32'h4);
      rd_chk("mask_swrst", 10'h010, 32'h0);
      rd_chk("sec_swrst", 10'h004, 32'h0);
      rd_chk("pop_swrst", 10'h00C, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
